// File: rtl/cont_pkg.sv
// Shared definitions for the set-up screen field counters: key codes, auto-repeat
// FSM encoding and two-digit BCD conversion helpers.
package cont_pkg;

  // Keypad 8 / keypad 2 scan codes.
  localparam logic [7:0] KEY_UP_CODE = 8'h75;
  localparam logic [7:0] KEY_DN_CODE = 8'h72;

  // Auto-repeat FSM encoding.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDelay  = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  // Binary (0..99) to packed two-digit BCD.
  function automatic logic [7:0] bin2bcd(input logic [7:0] v);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = v / 8'd10;
    units = v - tens * 8'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  // Packed two-digit BCD to binary; only meaningful when bcd_ok() holds.
  function automatic logic [7:0] bcd2bin(input logic [7:0] b);
    return {4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]};
  endfunction

  // Both nibbles are decimal digits.
  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rep_tecla.sv
// Keyboard auto-repeat: one step on a fresh key strobe, then after REP_DELAY cycles
// of holding, one step every REP_RATE cycles until the key is released or the
// field is deselected.
module rep_tecla
  import cont_pkg::*;
#(
  parameter logic [7:0]  KEY_UP    = KEY_UP_CODE,
  parameter logic [7:0]  KEY_DN    = KEY_DN_CODE,
  parameter int unsigned REP_DELAY = 50_000_000,
  parameter int unsigned REP_RATE  = 10_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       activo_i,
  input  logic       en_codigo_i,
  input  logic       key_held_i,
  input  logic [7:0] key_code_i,
  output logic       step_up_o,
  output logic       step_dn_o
);

  localparam int unsigned CntMax = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DelayLast = CntW'(REP_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REP_RATE - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_up_q, dir_up_d;
  logic            step;
  logic            key_up, key_dn;

  assign key_up = (key_code_i == KEY_UP);
  assign key_dn = (key_code_i == KEY_DN);

  // Next-state: load clears, a fresh key restarts from any state, else count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    step     = 1'b0;
    if (clr_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (activo_i && en_codigo_i && (key_up || key_dn)) begin
      step     = 1'b1;
      dir_up_d = key_up;
      cnt_d    = '0;
      state_d  = StDelay;
    end else begin
      case (state_q)
        StDelay: begin
          if (!key_held_i || !activo_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == DelayLast) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = StRepeat;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (!key_held_i || !activo_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == RateLast) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // Idle, and recovery from the unused encoding.
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and latched direction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
    end
  end

  // dir_up_d already holds the new direction on a fresh key.
  assign step_up_o = step && dir_up_d;
  assign step_dn_o = step && !dir_up_d;

endmodule

// File: rtl/cont_campo_bcd.sv
// One date/time field of the set-up screen: binary value with a registered BCD
// copy, run-time upper limit, RTC load and keyboard auto-repeat.
module cont_campo_bcd
  import cont_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned P         = 2,
  parameter int unsigned W         = 7,
  parameter int unsigned CAMPO     = 2,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = 99,
  parameter logic [7:0]  KEY_UP    = KEY_UP_CODE,
  parameter logic [7:0]  KEY_DN    = KEY_DN_CODE,
  parameter int unsigned REP_DELAY = 50_000_000,
  parameter int unsigned REP_RATE  = 10_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] posicion,
  input  logic         f2,
  input  logic         en_codigo,
  input  logic         key_held,
  input  logic [7:0]   key_code,
  input  logic         load,
  input  logic [N-1:0] load_bcd,
  input  logic [W-1:0] lim_max,
  output logic [N-1:0] dato,
  output logic [W-1:0] valor_bin,
  output logic         wrap_up,
  output logic         wrap_dn
);

  localparam logic [W-1:0] MinW = W'(MIN_VAL);
  localparam logic [W-1:0] MaxW = W'(MAX_VAL);

  logic [W-1:0] value_q, value_d;
  logic [N-1:0] dato_q, dato_d;
  logic         wrap_up_q, wrap_up_d;
  logic         wrap_dn_q, wrap_dn_d;
  logic [W-1:0] eff_max;
  logic         activo;
  logic         step_up, step_dn;
  logic [7:0]   load_val;

  assign activo   = (posicion == P'(CAMPO)) && f2;
  assign load_val = bcd2bin(load_bcd[7:0]);

  // Effective ceiling: lim_max bounded to [MIN_VAL, MAX_VAL].
  always_comb begin
    if (lim_max < MinW) begin
      eff_max = MinW;
    end else if (lim_max > MaxW) begin
      eff_max = MaxW;
    end else begin
      eff_max = lim_max;
    end
  end

  rep_tecla #(
    .KEY_UP    (KEY_UP),
    .KEY_DN    (KEY_DN),
    .REP_DELAY (REP_DELAY),
    .REP_RATE  (REP_RATE)
  ) u_rep_tecla (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (load),
    .activo_i    (activo),
    .en_codigo_i (en_codigo),
    .key_held_i  (key_held),
    .key_code_i  (key_code),
    .step_up_o   (step_up),
    .step_dn_o   (step_dn)
  );

  // Next value: load beats clamp beats step; load and clamp swallow any step.
  always_comb begin
    value_d   = value_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    if (load) begin
      // Compare in 32 bits so out-of-range loads clamp instead of truncating.
      if (bcd_ok(load_bcd[7:0])) begin
        if (32'(load_val) < 32'(MinW)) begin
          value_d = MinW;
        end else if (32'(load_val) > 32'(eff_max)) begin
          value_d = eff_max;
        end else begin
          value_d = W'(load_val);
        end
      end
    end else if (value_q > eff_max) begin
      value_d = eff_max;
    end else if (step_up) begin
      if (value_q == eff_max) begin
        value_d   = MinW;
        wrap_up_d = 1'b1;
      end else begin
        value_d = value_q + 1'b1;
      end
    end else if (step_dn) begin
      if (value_q == MinW) begin
        value_d   = eff_max;
        wrap_dn_d = 1'b1;
      end else begin
        value_d = value_q - 1'b1;
      end
    end
    dato_d = N'(bin2bcd(8'(value_d)));
  end

  // Binary and BCD copies update together from the same next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q   <= MinW;
      dato_q    <= N'(bin2bcd(8'(MinW)));
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      dato_q    <= dato_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
    end
  end

  assign dato      = dato_q;
  assign valor_bin = value_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_dn   = wrap_dn_q;

endmodule

// File: tb/tb_cont_campo_bcd.sv
// Scoreboard bench for cont_campo_bcd: two instances (0..99 and 1..31 fields),
// expectations queued per cycle by the stimulus and checked by a monitor.
module tb_cont_campo_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] posicion;
  logic       f2_a, f2_b;
  logic       en_codigo;
  logic       key_held;
  logic [7:0] key_code;
  logic       load_a, load_b;
  logic [7:0] load_bcd;
  logic [6:0] lim_a, lim_b;
  logic [7:0] dato_a, dato_b;
  logic [6:0] bin_a, bin_b;
  logic       wu_a, wd_a, wu_b, wd_b;

  always #5 clk = ~clk;

  cont_campo_bcd #(
    .N(8), .P(2), .W(7), .CAMPO(2), .MIN_VAL(0), .MAX_VAL(99),
    .KEY_UP(8'h75), .KEY_DN(8'h72), .REP_DELAY(4), .REP_RATE(2)
  ) dut_a (
    .clk(clk), .rst(rst), .posicion(posicion), .f2(f2_a), .en_codigo(en_codigo),
    .key_held(key_held), .key_code(key_code), .load(load_a), .load_bcd(load_bcd),
    .lim_max(lim_a), .dato(dato_a), .valor_bin(bin_a), .wrap_up(wu_a), .wrap_dn(wd_a)
  );

  cont_campo_bcd #(
    .N(8), .P(2), .W(7), .CAMPO(2), .MIN_VAL(1), .MAX_VAL(31),
    .KEY_UP(8'h75), .KEY_DN(8'h72), .REP_DELAY(4), .REP_RATE(2)
  ) dut_b (
    .clk(clk), .rst(rst), .posicion(posicion), .f2(f2_b), .en_codigo(en_codigo),
    .key_held(key_held), .key_code(key_code), .load(load_b), .load_bcd(load_bcd),
    .lim_max(lim_b), .dato(dato_b), .valor_bin(bin_b), .wrap_up(wu_b), .wrap_dn(wd_b)
  );

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] dato;
    logic [6:0] bin;
    logic       wu;
    logic       wd;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation for the cycle dly cycles from now.
  task automatic exp_push(input int dly, input int id, input logic [7:0] d,
                          input logic [6:0] b, input logic wu, input logic wd,
                          input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.id = id; e.dato = d; e.bin = b; e.wu = wu; e.wd = wd;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge and drop one-cycle strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    en_codigo = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
  endtask

  // Monitor: compare every expectation due by this cycle, on the falling edge.
  exp_t       me;
  logic [7:0] m_dato;
  logic [6:0] m_bin;
  logic       m_wu, m_wd;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      if (me.id == 0) begin
        m_dato = dato_a; m_bin = bin_a; m_wu = wu_a; m_wd = wd_a;
      end else begin
        m_dato = dato_b; m_bin = bin_b; m_wu = wu_b; m_wd = wd_b;
      end
      n_tests++;
      if ({m_dato, m_bin, m_wu, m_wd} !== {me.dato, me.bin, me.wu, me.wd}) begin
        n_fail++;
        $display("FAIL %s: got dato=%h bin=%0d wrap_up=%b wrap_dn=%b, want dato=%h bin=%0d wrap_up=%b wrap_dn=%b",
                 me.name, m_dato, m_bin, m_wu, m_wd, me.dato, me.bin, me.wu, me.wd);
      end
    end
  end

  localparam int A = 0;
  localparam int B = 1;

  initial begin
    rst = 1'b1; posicion = 2'd2; f2_a = 1'b0; f2_b = 1'b0; en_codigo = 1'b0;
    key_held = 1'b0; key_code = 8'h00; load_a = 1'b0; load_b = 1'b0;
    load_bcd = 8'h00; lim_a = 7'd99; lim_b = 7'd31;
    tick(); tick();
    rst = 1'b0;
    exp_push(0, A, 8'h00, 7'd0, 1'b0, 1'b0, "reset_a");
    exp_push(0, B, 8'h01, 7'd1, 1'b0, 1'b0, "reset_b");
    tick();

    // Load 37, then reset asynchronously mid-cycle.
    load_a = 1'b1; load_bcd = 8'h37;
    exp_push(1, A, 8'h37, 7'd37, 1'b0, 1'b0, "load37");
    tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (dato_a !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_dato_now: got dato=%h, want 00", dato_a);
    end
    n_tests++;
    if (bin_a !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset_bin_now: got bin=%0d, want 0", bin_a);
    end
    exp_push(0, A, 8'h00, 7'd0, 1'b0, 1'b0, "async_reset");
    tick();
    rst = 1'b0;
    tick();

    // Field 1..31: wrap up and wrap down.
    f2_b = 1'b1;
    load_b = 1'b1; load_bcd = 8'h31;
    exp_push(1, B, 8'h31, 7'd31, 1'b0, 1'b0, "load31");
    tick();
    en_codigo = 1'b1; key_code = 8'h75;
    exp_push(1, B, 8'h01, 7'd1, 1'b1, 1'b0, "wrap_up");
    exp_push(2, B, 8'h01, 7'd1, 1'b0, 1'b0, "wrap_up_one_cycle");
    tick();
    n_tests++;
    if (wu_b !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up_direct: got wrap_up=%b, want 1", wu_b);
    end
    tick();
    en_codigo = 1'b1; key_code = 8'h72;
    exp_push(1, B, 8'h31, 7'd31, 1'b0, 1'b1, "wrap_dn");
    exp_push(2, B, 8'h31, 7'd31, 1'b0, 1'b0, "wrap_dn_one_cycle");
    tick(); tick();

    // Limit drops to 28 with a simultaneous KEY_UP: clamp, step dropped.
    lim_b = 7'd28; en_codigo = 1'b1; key_code = 8'h75;
    exp_push(1, B, 8'h28, 7'd28, 1'b0, 1'b0, "clamp");
    exp_push(2, B, 8'h28, 7'd28, 1'b0, 1'b0, "clamp_hold");
    tick(); tick();
    load_b = 1'b1; load_bcd = 8'h35;
    exp_push(1, B, 8'h28, 7'd28, 1'b0, 1'b0, "load_clamp_max");
    tick();
    load_b = 1'b1; load_bcd = 8'h00;
    exp_push(1, B, 8'h01, 7'd1, 1'b0, 1'b0, "load_clamp_min");
    tick();
    f2_b = 1'b0;

    // Load beats a simultaneous KEY_DN; malformed BCD is ignored.
    f2_a = 1'b1;
    load_a = 1'b1; load_bcd = 8'h45; en_codigo = 1'b1; key_code = 8'h72;
    exp_push(1, A, 8'h45, 7'd45, 1'b0, 1'b0, "load_beats_key");
    exp_push(2, A, 8'h45, 7'd45, 1'b0, 1'b0, "load_fsm_idle");
    tick(); tick();
    load_a = 1'b1; load_bcd = 8'h4A;
    exp_push(1, A, 8'h45, 7'd45, 1'b0, 1'b0, "load_bad_bcd");
    tick();

    // Auto-repeat: steps at cycles 0, 4, 6, 8 while held for 10 cycles.
    load_a = 1'b1; load_bcd = 8'h10;
    exp_push(1, A, 8'h10, 7'd10, 1'b0, 1'b0, "load10");
    tick();
    en_codigo = 1'b1; key_code = 8'h75; key_held = 1'b1;
    exp_push(1, A, 8'h11, 7'd11, 1'b0, 1'b0, "rep_first");
    exp_push(4, A, 8'h11, 7'd11, 1'b0, 1'b0, "rep_delay_wait");
    exp_push(5, A, 8'h12, 7'd12, 1'b0, 1'b0, "rep_after_delay");
    exp_push(7, A, 8'h13, 7'd13, 1'b0, 1'b0, "rep_rate1");
    exp_push(9, A, 8'h14, 7'd14, 1'b0, 1'b0, "rep_rate2");
    exp_push(12, A, 8'h14, 7'd14, 1'b0, 1'b0, "rep_released");
    repeat (10) tick();
    key_held = 1'b0;
    repeat (3) tick();

    // Deselect during REPEAT stops stepping; reselecting alone does not step.
    load_a = 1'b1; load_bcd = 8'h20;
    exp_push(1, A, 8'h20, 7'd20, 1'b0, 1'b0, "load20");
    tick();
    en_codigo = 1'b1; key_code = 8'h75; key_held = 1'b1;
    exp_push(1, A, 8'h21, 7'd21, 1'b0, 1'b0, "desel_first");
    exp_push(5, A, 8'h22, 7'd22, 1'b0, 1'b0, "desel_delay_step");
    exp_push(9, A, 8'h22, 7'd22, 1'b0, 1'b0, "desel_stops");
    repeat (6) tick();
    f2_a = 1'b0;
    repeat (3) tick();
    f2_a = 1'b1;
    exp_push(2, A, 8'h22, 7'd22, 1'b0, 1'b0, "reselect_no_step");
    tick(); tick();
    key_held = 1'b0;

    // Keys ignored when not selected, and unrelated codes ignored.
    posicion = 2'd1; en_codigo = 1'b1; key_code = 8'h75;
    exp_push(1, A, 8'h22, 7'd22, 1'b0, 1'b0, "wrong_posicion");
    tick();
    posicion = 2'd2; f2_a = 1'b0; en_codigo = 1'b1; key_code = 8'h75;
    exp_push(1, A, 8'h22, 7'd22, 1'b0, 1'b0, "f2_off");
    tick();
    f2_a = 1'b1; en_codigo = 1'b1; key_code = 8'h1C;
    exp_push(1, A, 8'h22, 7'd22, 1'b0, 1'b0, "other_code");
    tick();
    en_codigo = 1'b1; key_code = 8'h72;
    exp_push(1, A, 8'h21, 7'd21, 1'b0, 1'b0, "step_down");
    tick();

    repeat (3) tick();
    n_tests++;
    if (dato_a !== 8'h21) begin
      n_fail++;
      $display("FAIL final_dato_a: got dato=%h, want 21", dato_a);
    end
    n_tests++;
    if (bin_b !== 7'd1) begin
      n_fail++;
      $display("FAIL final_bin_b: got bin=%0d, want 1", bin_b);
    end
    while (sb.size() > 0) begin
      me = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation never checked, want dato=%h", me.name, me.dato);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
